// File: rtl/ad_ip_jesd204_tpl_dac_start_ctrl.sv
// JESD204 TPL DAC start/stop sequencer (link_clk domain).
// Arms on a software request, waits for the selected trigger, then issues a
// one-cycle dac_sync and opens data_enable. It also tracks underflow and
// timeout status while running.
module ad_ip_jesd204_tpl_dac_start_ctrl #(
  parameter int unsigned TIMEOUT_WIDTH   = 16,
  parameter int unsigned UNF_COUNT_WIDTH = 16
) (
  input  logic                       link_clk,
  input  logic                       link_resetn,
  input  logic                       ctrl_arm,
  input  logic                       ctrl_disarm,
  input  logic                       ctrl_clear,
  input  logic [1:0]                 ctrl_mode,
  input  logic [TIMEOUT_WIDTH-1:0]   ctrl_timeout,
  input  logic                       link_ready,
  input  logic                       dac_external_sync,
  input  logic                       dac_dunf,
  output logic                       dac_sync,
  output logic                       data_enable,
  output logic [1:0]                 status_state,
  output logic                       status_timeout,
  output logic                       status_unf,
  output logic [UNF_COUNT_WIDTH-1:0] status_unf_count
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StArmed = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;

  localparam logic [1:0] ModeSync = 2'd1;
  localparam logic [1:0] ModeLink = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [1:0]                 mode_q, mode_d;
  logic                       sync_r, sync_rr;
  logic                       sync_edge;
  logic [TIMEOUT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                       dac_sync_q, dac_sync_d;
  logic                       timeout_q, timeout_d;
  logic                       unf_q, unf_d;
  logic [UNF_COUNT_WIDTH-1:0] unf_cnt_q, unf_cnt_d;
  logic                       trigger;
  logic                       expired;
  logic                       mode_q_waits;
  logic                       ctrl_mode_waits;

  assign sync_edge = sync_r & ~sync_rr;

  // Modes 1 and 2 wait for a trigger and follow link loss; 0 and 3 start at once.
  assign mode_q_waits    = (mode_q == ModeSync) || (mode_q == ModeLink);
  assign ctrl_mode_waits = (ctrl_mode == ModeSync) || (ctrl_mode == ModeLink);

  assign trigger = (mode_q == ModeSync) ? (sync_edge & link_ready) :
                   (mode_q == ModeLink) ? link_ready : 1'b0;

  assign expired = (ctrl_timeout != '0) &&
                   (cnt_q == ctrl_timeout - TIMEOUT_WIDTH'(1));

  // Next-state logic for the sequencer and its arm timeout counter.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    dac_sync_d = 1'b0;
    timeout_d  = timeout_q;

    if (ctrl_disarm) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (ctrl_arm) begin
            mode_d = ctrl_mode;
            if (ctrl_mode_waits) begin
              state_d = StArmed;
              cnt_d   = '0;
            end else begin
              state_d    = StRun;
              dac_sync_d = 1'b1;
            end
          end
        end
        StArmed: begin
          // A trigger landing on the expiry cycle still starts the run.
          if (trigger) begin
            state_d    = StRun;
            dac_sync_d = 1'b1;
          end else if (expired) begin
            state_d   = StIdle;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
          end
        end
        StRun: begin
          if (!link_ready && mode_q_waits) begin
            state_d = StArmed;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (ctrl_clear) begin
      timeout_d = 1'b0;
    end
  end

  // Underflow accounting while running; clear takes precedence over a count.
  always_comb begin
    unf_d     = unf_q;
    unf_cnt_d = unf_cnt_q;
    if (ctrl_clear) begin
      unf_d     = 1'b0;
      unf_cnt_d = '0;
    end else if ((state_q == StRun) && dac_dunf) begin
      unf_d = 1'b1;
      if (unf_cnt_q != '1) begin
        unf_cnt_d = unf_cnt_q + UNF_COUNT_WIDTH'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge link_clk) begin
    if (!link_resetn) begin
      state_q    <= StIdle;
      mode_q     <= 2'd0;
      sync_r     <= 1'b0;
      sync_rr    <= 1'b0;
      cnt_q      <= '0;
      dac_sync_q <= 1'b0;
      timeout_q  <= 1'b0;
      unf_q      <= 1'b0;
      unf_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      sync_r     <= dac_external_sync;
      sync_rr    <= sync_r;
      cnt_q      <= cnt_d;
      dac_sync_q <= dac_sync_d;
      timeout_q  <= timeout_d;
      unf_q      <= unf_d;
      unf_cnt_q  <= unf_cnt_d;
    end
  end

  assign dac_sync         = dac_sync_q;
  assign data_enable      = (state_q == StRun);
  assign status_state     = state_q;
  assign status_timeout   = timeout_q;
  assign status_unf       = unf_q;
  assign status_unf_count = unf_cnt_q;

endmodule
